// File: rtl/accum_pkg.sv
// Shared accumulator types and defaults: result/carry pair, default sizes, carry saturation.
package accum_pkg;

    localparam int ACC_WIDTH      = 32;
    localparam int ACC_FIFO_DEPTH = 4;

    localparam logic [7:0] CARRY_CNT_MAX = 8'hFF;

    typedef struct packed {
        logic [ACC_WIDTH-1:0] result;
        logic                 co;
    } acc_pair_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == CARRY_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/accum_result_fifo.sv
// Result/carry FIFO between accumulator and consumer, with a saturating carry statistic.
// Latency: one cycle push-to-head when empty, no fall-through; head is registered.
// Backpressure: in_ready drops at full from registered count only; out_ready never reaches in_ready.
module accum_result_fifo
    import accum_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int DEPTH = ACC_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_co,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_co,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               carry_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             co;
    } pair_t;

    pair_t          mem [DEPTH];
    pair_t          head;
    pair_t          wdat;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           push;
    logic           pop;

    always_comb begin
        in_ready  = (count != CW'(DEPTH));
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wdat      = '{result: in_result, co: in_co};
    end

    // head mirrors mem[rd_ptr] so the outputs come straight from a flop that resets to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            carry_cnt <= '0;
            head      <= '0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            carry_cnt <= '0;
            head      <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdat;
                wr_ptr      <= wr_ptr + 1'b1;
                if (in_co) begin
                    carry_cnt <= sat_inc8(carry_cnt);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // the incoming word becomes head when it lands in an empty (or emptying) FIFO
            if (push && ((count == '0) || (pop && count == CW'(1)))) begin
                head <= wdat;
            end else if (pop && count > CW'(1)) begin
                head <= mem[rd_ptr + 1'b1];
            end
        end
    end

    assign out_result = head.result;
    assign out_co     = head.co;

endmodule

// File: tb/tb_accum_result_fifo.sv
// Directed bench for accum_result_fifo with a queue reference model checked every cycle.
module tb_accum_result_fifo;

    localparam int W = 32;
    localparam int D = 4;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             clr       = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_co     = 1'b0;
    logic             out_ready = 1'b0;
    logic [W-1:0]     in_result = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_co;
    logic [W-1:0]     out_result;
    logic [$clog2(D):0] count;
    logic [7:0]       carry_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
    } ent_t;

    ent_t q[$];
    int   m_carry = 0;
    bit   m_pop;
    bit   m_push;

    always #5 clk = ~clk;

    accum_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_co      (in_co),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_co     (out_co),
        .count      (count),
        .carry_cnt  (carry_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain queue plus a saturating counter
    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            q.delete();
            m_carry = 0;
        end else begin
            m_pop  = (q.size() != 0) && out_ready;
            m_push = (q.size() != D) && in_valid;
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back('{in_result, in_co});
                if (in_co && m_carry < 255) m_carry++;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_count", count, q.size());
        chk("m_in_ready", in_ready, q.size() != D);
        chk("m_out_valid", out_valid, q.size() != 0);
        chk("m_carry_cnt", carry_cnt, m_carry);
        if (rst) begin
            chk("m_rst_result", out_result, 0);
            chk("m_rst_co", out_co, 0);
        end else if (q.size() != 0) begin
            chk("m_out_result", out_result, q[0].r);
            chk("m_out_co", out_co, q[0].c);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_carry", carry_cnt, 0);
        tick();
        tick();
        rst = 1'b0;

        // fill with 1..4, carry 0,1,0,1
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_result = W'(i + 1);
            in_co     = i[0];
            if (i == 0) begin
                #1 chk("no_fallthrough", out_valid, 0);
            end
            tick();
            if (i == 0) begin
                chk("latency_valid", out_valid, 1);
                chk("latency_result", out_result, 32'h1);
            end
        end
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_carry", carry_cnt, 2);
        chk("full_head", out_result, 32'h1);
        in_result = 32'h55;
        in_co     = 1'b1;
        tick();
        chk("blocked_count", count, 4);
        chk("blocked_carry", carry_cnt, 2);
        in_valid = 1'b0;

        // drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_result", out_result, i + 1);
            chk("drain_co", out_co, i & 1);
            tick();
        end
        chk("drained_valid", out_valid, 0);
        chk("drained_count", count, 0);
        tick();
        chk("pop_empty_count", count, 0);
        out_ready = 1'b0;

        // steady push+pop at count=2 across pointer wrap
        in_co     = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'h100;
        tick();
        in_result = 32'h101;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_result = W'(32'h102 + i);
            tick();
            chk("stream_count", count, 2);
            chk("stream_head", out_result, 32'h101 + i);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_tail", out_result, 32'h10B);
        tick();
        chk("stream_empty", out_valid, 0);

        // push+pop while full: only the pop happens
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_result = W'(32'h200 + i);
            tick();
        end
        out_ready = 1'b1;
        in_result = 32'h2FF;
        tick();
        chk("full_pp_count", count, 3);
        chk("full_pp_head", out_result, 32'h201);
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("full_pp_empty", out_valid, 0);

        // carry saturation
        in_valid = 1'b1;
        in_co    = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_result = W'(i);
            tick();
        end
        chk("sat_carry", carry_cnt, 255);
        in_valid = 1'b0;
        tick();
        chk("sat_hold", carry_cnt, 255);

        // clr overrides concurrent push and pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        tick();
        chk("pre_clr_count", count, 2);
        clr       = 1'b1;
        out_ready = 1'b1;
        in_result = 32'h77;
        tick();
        chk("clr_count", count, 0);
        chk("clr_carry", carry_cnt, 0);
        chk("clr_valid", out_valid, 0);
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("clr_discard", count, 0);

        // async reset mid-transfer
        in_valid = 1'b1;
        in_co    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_result = W'(32'h300 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", count, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_result", out_result, 0);
        tick();
        tick();
        #2 rst = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'hDEAD;
        in_co     = 1'b1;
        tick();
        chk("post_rst_head", out_result, 32'hDEAD);
        chk("post_rst_co", out_co, 1);
        chk("post_rst_count", count, 1);
        in_result = 32'hBEEF;
        in_co     = 1'b0;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_first", out_result, 32'hDEAD);
        tick();
        chk("post_rst_second", out_result, 32'hBEEF);
        tick();
        chk("post_rst_empty", out_valid, 0);
        chk("post_rst_carry", carry_cnt, 1);
        out_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_result_fifo.md
ACCUM_RESULT_FIFO -- requirements
Module: accum_result_fifo

Interface
REQ-001 Parameter WIDTH, default 32, result data width in bits.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clr  input  1  synchronous flush of contents and statistics.
REQ-006 in_valid  input  1  accumulator has a result/carry pair to deliver.
REQ-007 in_ready  output  1  FIFO accepts a pair this cycle.
REQ-008 in_result  input  WIDTH  accumulator result word.
REQ-009 in_co  input  1  accumulator carry-out for that result.
REQ-010 out_valid  output  1  head entry available to the consumer.
REQ-011 out_ready  input  1  consumer takes the head entry this cycle.
REQ-012 out_result  output  WIDTH  head entry result word.
REQ-013 out_co  output  1  head entry carry bit.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 carry_cnt  output  8  saturating count of accepted entries with in_co=1.

Function
REQ-016 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-017 in_ready SHALL equal (count != DEPTH), registered-state derived, with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_result/out_co SHALL present the oldest entry, with no combinational path from the inputs.
REQ-019 Latency: a pair pushed at edge N SHALL be visible on out_* after edge N (one cycle) when the FIFO was empty; no fall-through.
REQ-020 Entries SHALL leave in strict push order, result and carry travelling together unaltered.
REQ-021 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 Simultaneous push and pop: both performed; count unchanged; legal when full (pop frees slot only next cycle, so in_ready=0 prevents push at full) and when empty (pop impossible, push only).
REQ-023 Push when full SHALL be impossible by handshake; in_valid with in_ready=0 SHALL not change state.
REQ-024 Pop when empty SHALL not change state; out_result/out_co value is don't-care when out_valid=0.
REQ-025 carry_cnt SHALL increment by 1 on every push with in_co=1 and hold at 255.
REQ-026 clr=1 SHALL, at the edge, set pointers and count to 0 and carry_cnt to 0, overriding any concurrent push or pop.
REQ-027 Storage array contents need not be reset.

Reset
REQ-028 rst=1 SHALL asynchronously force count=0, pointers=0, carry_cnt=0, hence in_ready=1, out_valid=0.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; first push after rst deasserts SHALL be the first entry out.
REQ-030 out_result and out_co SHALL read 0 while in reset (head-register implementation resets to 0).

Structure
REQ-031 Shared package accum_pkg SHALL hold the result-pair struct (result WIDTH, co 1) and the default WIDTH/DEPTH constants, shared with the accumulator.
REQ-032 Single module, no sub-modules; pointer/count logic and storage in one always_ff, ready/valid in always_comb.

Verification
REQ-033 Reset then 4 pushes (0x1,0x2,0x3,0x4, co=0,1,0,1) with out_ready=0 -> count=4, in_ready=0, carry_cnt=2, out_result=0x1.
REQ-034 Full FIFO, out_ready=1 for 4 cycles, in_valid=0 -> out_result 0x1,0x2,0x3,0x4 with co 0,1,0,1, then out_valid=0, count=0.
REQ-035 count=2, in_valid=1 and out_ready=1 for 10 cycles with incrementing data -> count stays 2, order preserved across pointer wrap.
REQ-036 300 pushes with in_co=1, consumer always ready -> carry_cnt saturates at 255, no wrap to 0.
REQ-037 count=3, assert rst asynchronously between edges -> out_valid=0, in_ready=1, count=0 immediately; next push 0xDEAD reads out first.
REQ-038 count=2, clr=1 with in_valid=1 and out_ready=1 same cycle -> count=0, carry_cnt=0, pushed word discarded.
